mode_sequencer: RTL

Sequences the 4-bit display-mode word for the Basys3 sensor clock. It turns Next/Prev button presses and an optional auto-rotate timer into one of five mode codes. The code drives the mode decoder that enables the Clock, Stop_Watch, Timer, Ultra and DHT sub-systems. Leaving a sensor mode is deferred while that sensor's measurement is in progress, so a transaction is never cut off mid-frame.

---
 rtl/mode_sequencer_pkg.sv | 32 +++
 rtl/mode_sequencer_if.sv | 24 ++
 rtl/mode_sequencer_rise_edge_det.sv | 25 ++
 rtl/mode_sequencer.sv | 82 ++++++++
 4 files changed

// File: rtl/mode_sequencer_pkg.sv
// mode_pkg: display-mode codes, step directions and the ring-step helper
// shared by the sequencer, mode decoder and sensor controllers.
package mode_pkg;

    typedef enum logic [3:0] {
        MODE_CLOCK = 4'b0000,
        MODE_SW    = 4'b0001,
        MODE_TIMER = 4'b0010,
        MODE_ULTRA = 4'b0100,
        MODE_DHT   = 4'b1000
    } mode_t;

    typedef enum logic {
        DIR_NEXT = 1'b0,
        DIR_PREV = 1'b1
    } dir_t;

    function automatic mode_t step_mode(input mode_t m, input dir_t d);
        mode_t w_nx;
        mode_t w_pv;
        w_nx = m == MODE_CLOCK ? MODE_SW    :
               m == MODE_SW    ? MODE_TIMER :
               m == MODE_TIMER ? MODE_ULTRA :
               m == MODE_ULTRA ? MODE_DHT   : MODE_CLOCK;
        w_pv = m == MODE_CLOCK ? MODE_DHT   :
               m == MODE_SW    ? MODE_CLOCK :
               m == MODE_TIMER ? MODE_SW    :
               m == MODE_ULTRA ? MODE_TIMER : MODE_ULTRA;
        return d == DIR_NEXT ? w_nx : w_pv;
    endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: button/timer/busy inputs and mode outputs of the sequencer.
interface mode_sequencer_if;

    logic       iBtn_Next;
    logic       iBtn_Prev;
    logic       iAuto_En;
    logic       iTick_1Hz;
    logic       iBusy_Ultra;
    logic       iBusy_DHT;
    logic [3:0] oMode;
    logic       oMode_Chg;
    logic       oPending;

    modport master (
        output iBtn_Next, iBtn_Prev, iAuto_En, iTick_1Hz, iBusy_Ultra, iBusy_DHT,
        input  oMode, oMode_Chg, oPending
    );

    modport slave (
        input  iBtn_Next, iBtn_Prev, iAuto_En, iTick_1Hz, iBusy_Ultra, iBusy_DHT,
        output oMode, oMode_Chg, oPending
    );

endinterface

// File: rtl/mode_sequencer_rise_edge_det.sv
// rise_edge_det: samples a level and flags its rising edge; history resets
// high so a level held across reset never looks like a fresh press.
module rise_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_lvl;
    logic r_hist;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lvl  <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_lvl  <= i_level;
            r_hist <= r_lvl;
        end
    end

    assign o_rise = r_lvl & ~r_hist;

endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: steps the display-mode ring from buttons or the auto timer,
// deferring a step out of a sensor mode while that sensor is busy.
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int AUTO_SEC = 5
) (
    input  logic             iClk,
    input  logic             iRst,
    mode_sequencer_if.slave  bus
);

    logic       w_next_e;
    logic       w_prev_e;
    logic       w_any_e;
    logic       w_man;
    logic       w_dwell_hit;
    logic       w_auto;
    logic       w_req;
    logic       w_blocked;
    logic       w_man_applied;
    dir_t       w_dir;
    mode_t      r_mode;
    logic       r_chg;
    logic       r_pend;
    dir_t       r_pend_dir;
    logic [3:0] r_dwell;
    logic       r_busy_u;
    logic       r_busy_d;

    rise_edge_det u_next (.i_clk(iClk), .i_rst(iRst), .i_level(bus.iBtn_Next), .o_rise(w_next_e));
    rise_edge_det u_prev (.i_clk(iClk), .i_rst(iRst), .i_level(bus.iBtn_Prev), .o_rise(w_prev_e));

    assign w_any_e       = w_next_e | w_prev_e;
    assign w_man         = w_next_e ^ w_prev_e;
    assign w_dir         = (w_man & w_prev_e) ? DIR_PREV : DIR_NEXT;
    assign w_dwell_hit   = bus.iAuto_En & bus.iTick_1Hz & (r_dwell == 4'(AUTO_SEC - 1));
    // any button edge, even a cancelled Next+Prev pair, suppresses the auto step
    assign w_auto        = w_dwell_hit & ~w_any_e;
    assign w_req         = w_man | w_auto;
    assign w_blocked     = (r_mode == MODE_ULTRA & r_busy_u) | (r_mode == MODE_DHT & r_busy_d);
    assign w_man_applied = w_man & ~r_pend & ~w_blocked;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_mode     <= MODE_CLOCK;
            r_chg      <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_dir <= DIR_NEXT;
            r_dwell    <= 4'd0;
            r_busy_u   <= 1'b0;
            r_busy_d   <= 1'b0;
        end else begin
            r_busy_u <= bus.iBusy_Ultra;
            r_busy_d <= bus.iBusy_DHT;
            r_chg    <= 1'b0;
            r_dwell  <= (~bus.iAuto_En | w_dwell_hit | w_man_applied) ? 4'd0 : r_dwell + 4'(bus.iTick_1Hz);
            if (r_pend) begin
                if (!w_blocked) begin
                    r_mode <= step_mode(r_mode, r_pend_dir);
                    r_chg  <= 1'b1;
                    r_pend <= 1'b0;
                end else if (w_req && w_dir != r_pend_dir) begin
                    r_pend <= 1'b0;
                end
            end else if (w_req) begin
                if (w_blocked) begin
                    r_pend     <= 1'b1;
                    r_pend_dir <= w_dir;
                end else begin
                    r_mode <= step_mode(r_mode, w_dir);
                    r_chg  <= 1'b1;
                end
            end
        end
    end

    assign bus.oMode     = r_mode;
    assign bus.oMode_Chg = r_chg;
    assign bus.oPending  = r_pend;

endmodule
